alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port arbiter and sequencer that shares the single 32-bit `alu` between two requesters, such as the execute stage and a debug/CSR helper. It accepts one operation at a time through valid/ready handshakes and registers the operands into the ALU. It captures `ALUOut`/`BranchCondition` one cycle later, cleans the result per op class, and returns it on a per-port response handshake. Arbitration between ports is round-robin or fixed priority.

## Interface
- `FAIR`, default 1: 1 selects round-robin arbitration; 0 selects fixed priority with port 0 winning.
- `clk` in 1: single clock; everything is on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req0_valid` in 1: port 0 has an operation pending.
- `req0_ready` out 1: port 0 operation accepted this cycle.
- `req0_a` in 32: port 0 operand a.
- `req0_b` in 32: port 0 operand b.
- `req0_op` in 4: port 0 ALUOp encoding.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_op`: same as port 0, for port 1.
- `rsp0_valid` out 1: result ready for port 0.
- `rsp0_ready` in 1: port 0 consumes the result.
- `rsp0_out` out 32: cleaned ALU result.
- `rsp0_cond` out 1: cleaned branch condition.
- `rsp1_valid`, `rsp1_ready`, `rsp1_out`, `rsp1_cond`: same as port 0, for port 1.
- `alu_a` out 32: drives ALU `a`.
- `alu_b` out 32: drives ALU `b`.
- `alu_op` out 4: drives ALU `ALUOp`.
- `alu_out` in 32: from ALU `ALUOut`.
- `alu_cond` in 1: from ALU `BranchCondition`.

## Operation
- FSM has three states: IDLE, EXEC, RESP. Reset state is IDLE.
- **IDLE**
  - `reqN_ready` is combinational and asserted only for the arbitration winner, and only while at least one valid is high.
  - Single valid: that port wins.
  - Both valid, FAIR=1: the port not in `last_grant` wins.
  - Both valid, FAIR=0: port 0 always wins.
  - On handshake (`valid && ready`):
    - Latch a/b/op into operand registers.
    - Latch `owner` = winning port.
    - Set `last_grant` = owner.
    - Go to EXEC.
- **EXEC**
  - Operand registers drive `alu_a`/`alu_b`/`alu_op`; the ALU is combinational.
  - At the end of the cycle, capture the cleaned result into result registers and go to RESP.
- **Cleaning rules**
  - Ops 0000–0111 and 1110: out = `alu_out`, cond = 0.
  - Ops 1000–1101: out = 0, cond = `alu_cond`.
  - Op 1111: out = 0, cond = 0; the ALU inputs are ignored.
- **RESP**
  - `rspN_valid` = 1 for `owner` only; the other port's `rspN_valid` = 0.
  - `rspN_out`/`rspN_cond` hold steady until the handshake.
  - On `rspN_ready`: go to IDLE; `rsp_valid` deasserts next cycle.
  - The non-owner port's `rsp_ready` is ignored.
- Requesters hold valid and operands stable until ready.
  - Dropping valid before ready is legal and has no side effects.
  - A port's valid high during EXEC/RESP is simply not granted, since ready is 0 outside IDLE.
- While the FSM is outside IDLE, `alu_a`/`alu_b`/`alu_op` hold the last accepted operation. They are never driven from unregistered request inputs.

## Timing
- **Reset values**
  - `alu_a`=0, `alu_b`=0, `alu_op`=0.
  - `rsp0_out`/`rsp1_out`=0, `rsp0_cond`/`rsp1_cond`=0.
  - `rsp0_valid`/`rsp1_valid`=0.
  - `last_grant`=1, so port 0 wins the first contention.
  - `req0_ready`/`req1_ready` are gated low while `rst_n`=0.
- **Latency**
  - Handshake at edge T0.
  - Result registered at T1; `rsp_valid` is high in cycle T1–T2.
  - With `rsp_ready` held high, response completes at T2 and the FSM is IDLE in cycle T2–T3.
  - Earliest next accept is edge T3: one operation per 3 cycles peak.
- **Response stall**: with `rsp_ready` low, the FSM stays in RESP indefinitely. Outputs are stable and no new request is accepted.
- **Same-cycle events**
  - Both valid in IDLE: exactly one ready is asserted; the other is 0.
  - The same port re-requests in the IDLE cycle right after its response: it is granted only if the other port is not valid (FAIR=1).
- **Reset mid-operation**: `rst_n` low in EXEC or RESP aborts the operation. No response is issued, and all outputs take their reset values at the next edge.

## Test plan
- **Single ADD**: port 0 issues a=5, b=7, op=0000. Require:
  - `req0_ready` in the first cycle.
  - `rsp0_valid` exactly 2 cycles after the handshake, with `rsp0_out`=12, `rsp0_cond`=0.
- **Compare cleaning**: port 1 issues a=3, b=9, op=1000 (SLT) → `rsp1_cond`=1, `rsp1_out`=0. Then op=0000 with `alu_cond` forced to 1 by the bench → `rsp1_cond`=0.
- **Round-robin**: both ports hold valid for 4 ops each with FAIR=1.
  - Grant order 0,1,0,1,…
  - Each response appears only on the owner's port.
  - With FAIR=0, all port 0 ops complete first.
- **Backpressure**: `rsp0_ready` is held low 10 cycles after `rsp0_valid`. Require:
  - `rsp0_out` stable throughout.
  - `req1_ready` stays 0 despite `req1_valid`=1.
  - Port 1 is granted in the IDLE cycle after `rsp0_ready` rises.
- **Reserved op and shifts**
  - op=1111 → out=0, cond=0.
  - a=0x80000000, b=4, op=0110 → out=0x08000000.
  - a=1, b=31, op=0101 → out=0x80000000.
- **Mid-op reset**: `rst_n` is pulsed low for one cycle during EXEC, then again during RESP. Require:
  - No `rsp_valid` afterwards.
  - All outputs 0 at the next edge.
  - The next request is accepted normally, with port 0 winning contention.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational 32-bit ALU between two requesters.
// Operands are registered into the ALU; the cleaned result returns on the owner's response port.
module alu_arbiter #(
  parameter logic FAIR = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_op,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_out,
  output logic        rsp0_cond,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_out,
  output logic        rsp1_cond,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_out,
  input  logic        alu_cond
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_r;
  logic        owner_r;
  logic        last_grant_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [3:0]  op_r;
  logic [31:0] out0_r;
  logic [31:0] out1_r;
  logic        cond0_r;
  logic        cond1_r;
  logic        rsp0_valid_r;
  logic        rsp1_valid_r;

  logic        grant_s;
  logic        any_valid_s;
  logic        ready0_s;
  logic        ready1_s;
  logic        accept_s;
  logic        rsp_hs_s;
  logic [31:0] acc_a_s;
  logic [31:0] acc_b_s;
  logic [3:0]  acc_op_s;
  logic [32:0] clean_s;

  // Result cleaning by op class: {out, cond}. Arithmetic/logic ops keep out,
  // compares keep cond, the reserved op yields all zeros.
  function automatic logic [32:0] clean_result(input logic [3:0]  op,
                                               input logic [31:0] out,
                                               input logic        cond);
    logic [32:0] res;
    case (op)
      4'b1111: res = 33'd0;
      4'b1110: res = {out, 1'b0};
      default: begin
        if (op[3]) begin
          res = {32'd0, cond};
        end else begin
          res = {out, 1'b0};
        end
      end
    endcase
    return res;
  endfunction

  // Arbitration winner among the currently valid ports.
  always_comb begin
    any_valid_s = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      if (FAIR) begin
        grant_s = ~last_grant_r;
      end else begin
        grant_s = 1'b0;
      end
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Request ready: only in IDLE, only to the winner, gated while in reset.
  always_comb begin
    if (rst_n && (state_r == ST_IDLE) && any_valid_s) begin
      ready0_s = ~grant_s & req0_valid;
      ready1_s = grant_s & req1_valid;
    end else begin
      ready0_s = 1'b0;
      ready1_s = 1'b0;
    end
  end

  // Operand selection from the winning port.
  always_comb begin
    if (grant_s) begin
      acc_a_s  = req1_a;
      acc_b_s  = req1_b;
      acc_op_s = req1_op;
    end else begin
      acc_a_s  = req0_a;
      acc_b_s  = req0_b;
      acc_op_s = req0_op;
    end
  end

  // Handshake detection and cleaned ALU result.
  always_comb begin
    accept_s = ready0_s | ready1_s;
    if (owner_r) begin
      rsp_hs_s = rsp1_valid_r & rsp1_ready;
    end else begin
      rsp_hs_s = rsp0_valid_r & rsp0_ready;
    end
    clean_s = clean_result(op_r, alu_out, alu_cond);
  end

  // Sequencer: accept in IDLE, capture in EXEC, wait for the owner's response handshake in RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      owner_r      <= 1'b0;
      last_grant_r <= 1'b1;
      a_r          <= 32'd0;
      b_r          <= 32'd0;
      op_r         <= 4'd0;
      out0_r       <= 32'd0;
      out1_r       <= 32'd0;
      cond0_r      <= 1'b0;
      cond1_r      <= 1'b0;
      rsp0_valid_r <= 1'b0;
      rsp1_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            a_r          <= acc_a_s;
            b_r          <= acc_b_s;
            op_r         <= acc_op_s;
            owner_r      <= grant_s;
            last_grant_r <= grant_s;
            state_r      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (owner_r) begin
            out1_r       <= clean_s[32:1];
            cond1_r      <= clean_s[0];
            rsp1_valid_r <= 1'b1;
          end else begin
            out0_r       <= clean_s[32:1];
            cond0_r      <= clean_s[0];
            rsp0_valid_r <= 1'b1;
          end
          state_r <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_hs_s) begin
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
            state_r      <= ST_IDLE;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          rsp0_valid_r <= 1'b0;
          rsp1_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign req0_ready = ready0_s;
  assign req1_ready = ready1_s;
  assign rsp0_valid = rsp0_valid_r;
  assign rsp1_valid = rsp1_valid_r;
  assign rsp0_out   = out0_r;
  assign rsp1_out   = out1_r;
  assign rsp0_cond  = cond0_r;
  assign rsp1_cond  = cond1_r;
  assign alu_a      = a_r;
  assign alu_b      = b_r;
  assign alu_op     = op_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: behavioural ALU plus a rule-level reference
// for result cleaning and grant order; round-robin and fixed-priority instances.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic        rsp0_ready, rsp1_ready;
  logic        force_cond;
  logic        sel_fp;

  logic        m_req0_ready, m_req1_ready, m_rsp0_valid, m_rsp1_valid, m_rsp0_cond, m_rsp1_cond;
  logic [31:0] m_rsp0_out, m_rsp1_out, m_alu_a, m_alu_b, m_alu_out;
  logic [3:0]  m_alu_op;
  logic        m_alu_cond;
  logic [32:0] m_alu_raw;
  logic        f_req0_ready, f_req1_ready, f_rsp0_valid, f_rsp1_valid, f_rsp0_cond, f_rsp1_cond;
  logic [31:0] f_rsp0_out, f_rsp1_out, f_alu_a, f_alu_b, f_alu_out;
  logic [3:0]  f_alu_op;
  logic        f_alu_cond;
  logic [32:0] f_alu_raw;

  logic        obs_req0_ready, obs_req1_ready, obs_rsp0_valid, obs_rsp1_valid;
  logic        obs_rsp0_cond, obs_rsp1_cond;
  logic [31:0] obs_rsp0_out, obs_rsp1_out, obs_alu_a, obs_alu_b;
  logic [3:0]  obs_alu_op;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural ALU: raw out/cond for every op, including junk on the class that gets cleaned.
  function automatic logic [32:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
    logic [31:0] o;
    logic        c;
    case (op[2:0])
      3'd0:    o = a + b;
      3'd1:    o = a - b;
      3'd2:    o = a & b;
      3'd3:    o = a | b;
      3'd4:    o = a ^ b;
      3'd5:    o = a << b[4:0];
      3'd6:    o = a >> b[4:0];
      default: o = 32'($signed(a) >>> b[4:0]);
    endcase
    case (op[2:0])
      3'd0:    c = ($signed(a) < $signed(b));
      3'd1:    c = (a < b);
      3'd2:    c = (a == b);
      3'd3:    c = (a != b);
      3'd4:    c = ($signed(a) >= $signed(b));
      3'd5:    c = (a >= b);
      default: c = a[0] ^ b[0];
    endcase
    if (op == 4'd14) o = b;
    if (op == 4'd15) begin
      o = ~a;
      c = 1'b1;
    end
    return {o, c};
  endfunction

  // Expected response {out, cond} straight from the cleaning rules.
  function automatic logic [32:0] expect_rsp(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] op);
    logic [32:0] raw;
    raw = alu_model(a, b, op);
    if (op == 4'd15) return 33'd0;
    if (op >= 4'd8 && op <= 4'd13) return {32'd0, raw[0]};
    return {raw[32:1], 1'b0};
  endfunction

  assign m_alu_raw  = alu_model(m_alu_a, m_alu_b, m_alu_op);
  assign m_alu_out  = m_alu_raw[32:1];
  assign m_alu_cond = m_alu_raw[0] | force_cond;
  assign f_alu_raw  = alu_model(f_alu_a, f_alu_b, f_alu_op);
  assign f_alu_out  = f_alu_raw[32:1];
  assign f_alu_cond = f_alu_raw[0] | force_cond;

  assign obs_req0_ready = sel_fp ? f_req0_ready : m_req0_ready;
  assign obs_req1_ready = sel_fp ? f_req1_ready : m_req1_ready;
  assign obs_rsp0_valid = sel_fp ? f_rsp0_valid : m_rsp0_valid;
  assign obs_rsp1_valid = sel_fp ? f_rsp1_valid : m_rsp1_valid;
  assign obs_rsp0_out   = sel_fp ? f_rsp0_out   : m_rsp0_out;
  assign obs_rsp1_out   = sel_fp ? f_rsp1_out   : m_rsp1_out;
  assign obs_rsp0_cond  = sel_fp ? f_rsp0_cond  : m_rsp0_cond;
  assign obs_rsp1_cond  = sel_fp ? f_rsp1_cond  : m_rsp1_cond;
  assign obs_alu_a      = sel_fp ? f_alu_a      : m_alu_a;
  assign obs_alu_b      = sel_fp ? f_alu_b      : m_alu_b;
  assign obs_alu_op     = sel_fp ? f_alu_op     : m_alu_op;

  alu_arbiter #(.FAIR(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(m_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(m_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(m_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_out(m_rsp0_out), .rsp0_cond(m_rsp0_cond),
    .rsp1_valid(m_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_out(m_rsp1_out), .rsp1_cond(m_rsp1_cond),
    .alu_a(m_alu_a), .alu_b(m_alu_b), .alu_op(m_alu_op), .alu_out(m_alu_out), .alu_cond(m_alu_cond)
  );

  alu_arbiter #(.FAIR(1'b0)) u_dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(f_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_out(f_rsp0_out), .rsp0_cond(f_rsp0_cond),
    .rsp1_valid(f_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_out(f_rsp1_out), .rsp1_cond(f_rsp1_cond),
    .alu_a(f_alu_a), .alu_b(f_alu_b), .alu_op(f_alu_op), .alu_out(f_alu_out), .alu_cond(f_alu_cond)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_req(input bit port, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] op);
    if (port) begin
      req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    set_req(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issues one op and collects the response; comparisons are made by the callers.
  task automatic run_op(input bit port, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, output logic [32:0] got, output int wait_cyc,
                        output int lat, output bit timeout);
    int n;
    timeout = 1'b0; lat = -1; got = 33'd0; wait_cyc = 0;
    @(negedge clk);
    set_req(port, 1'b1, a, b, op);
    #1;
    while (!(port ? obs_req1_ready : obs_req0_ready)) begin
      if (wait_cyc == 20) begin
        timeout = 1'b1;
        set_req(port, 1'b0, a, b, op);
        return;
      end
      @(negedge clk); #1; wait_cyc++;
    end
    @(posedge clk);
    #1 set_req(port, 1'b0, a, b, op);
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!(port ? obs_rsp1_valid : obs_rsp0_valid) && n < 20);
    if (!(port ? obs_rsp1_valid : obs_rsp0_valid)) begin
      timeout = 1'b1;
      return;
    end
    lat = n;
    got = port ? {obs_rsp1_out, obs_rsp1_cond} : {obs_rsp0_out, obs_rsp0_cond};
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_req(1'b0, 1'b1, 32'd1, 32'd2, 4'd0);
    set_req(1'b1, 1'b1, 32'd3, 32'd4, 4'd0);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({obs_req0_ready, obs_req1_ready} !== 2'b00)
      $display("FAIL reset_ready got=%b want=00", {obs_req0_ready, obs_req1_ready});
    else n_pass++;
    n_checks++;
    if ({obs_alu_a, obs_alu_b, obs_alu_op} !== 68'd0)
      $display("FAIL reset_alu got a=%h b=%h op=%h want 0", obs_alu_a, obs_alu_b, obs_alu_op);
    else n_pass++;
    n_checks++;
    if ({obs_rsp0_valid, obs_rsp1_valid, obs_rsp0_out, obs_rsp1_out, obs_rsp0_cond, obs_rsp1_cond} !== 68'd0)
      $display("FAIL reset_rsp got v=%b%b out0=%h out1=%h c=%b%b want 0", obs_rsp0_valid, obs_rsp1_valid,
               obs_rsp0_out, obs_rsp1_out, obs_rsp0_cond, obs_rsp1_cond);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_single_add();
    logic [32:0] got; int w, lat; bit to;
    run_op(1'b0, 32'd5, 32'd7, 4'b0000, got, w, lat, to);
    n_checks++;
    if ({to, w} !== {1'b0, 32'd0}) $display("FAIL add_ready_first got timeout=%0d wait=%0d want 0,0", to, w);
    else n_pass++;
    n_checks++;
    if (lat !== 2) $display("FAIL add_latency got=%0d want=2", lat);
    else n_pass++;
    n_checks++;
    if (got !== {32'd12, 1'b0}) $display("FAIL add_result got=%h/%b want=0000000c/0", got[32:1], got[0]);
    else n_pass++;
  endtask

  task automatic test_compare_cleaning();
    logic [32:0] got; int w, lat; bit to;
    run_op(1'b1, 32'd3, 32'd9, 4'b1000, got, w, lat, to);
    n_checks++;
    if ({to, got} !== {1'b0, 32'd0, 1'b1}) $display("FAIL slt_clean got=%h/%b to=%0d want=0/1", got[32:1], got[0], to);
    else n_pass++;
    force_cond = 1'b1;
    run_op(1'b1, 32'd3, 32'd9, 4'b0000, got, w, lat, to);
    force_cond = 1'b0;
    n_checks++;
    if ({to, got} !== {1'b0, 32'd12, 1'b0}) $display("FAIL add_cond_clean got=%h/%b to=%0d want=c/0", got[32:1], got[0], to);
    else n_pass++;
  endtask

  task automatic test_reserved_shifts();
    logic [32:0] got; int w, lat; bit to;
    run_op(1'b0, $urandom, $urandom, 4'b1111, got, w, lat, to);
    n_checks++;
    if ({to, got} !== 34'd0) $display("FAIL reserved_op got=%h/%b to=%0d want=0/0", got[32:1], got[0], to);
    else n_pass++;
    run_op(1'b1, 32'h8000_0000, 32'd4, 4'b0110, got, w, lat, to);
    n_checks++;
    if ({to, got} !== {1'b0, 32'h0800_0000, 1'b0}) $display("FAIL srl got=%h to=%0d want=08000000", got[32:1], to);
    else n_pass++;
    run_op(1'b0, 32'd1, 32'd31, 4'b0101, got, w, lat, to);
    n_checks++;
    if ({to, got} !== {1'b0, 32'h8000_0000, 1'b0}) $display("FAIL sll got=%h to=%0d want=80000000", got[32:1], to);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] a0, b0, a1, b1;
    logic [32:0] exp0;
    int n;
    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
    exp0 = expect_rsp(a0, b0, 4'b0010);
    @(negedge clk);
    rsp0_ready = 1'b0;
    set_req(1'b0, 1'b1, a0, b0, 4'b0010);
    #1;
    n_checks++;
    if (obs_req0_ready !== 1'b1) $display("FAIL bp_accept got=%b want=1", obs_req0_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    set_req(1'b0, 1'b0, a0, b0, 4'b0010);
    set_req(1'b1, 1'b1, a1, b1, 4'b0100);
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!obs_rsp0_valid && n < 10);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if ({obs_rsp0_valid, obs_rsp0_out, obs_rsp0_cond, obs_req1_ready} !== {1'b1, exp0, 1'b0})
        $display("FAIL bp_hold cyc=%0d got v=%b out=%h r1=%b want v=1 out=%h r1=0", i, obs_rsp0_valid,
                 obs_rsp0_out, obs_req1_ready, exp0[32:1]);
      else n_pass++;
      @(negedge clk); #1;
    end
    rsp0_ready = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if ({obs_rsp0_valid, obs_req1_ready} !== 2'b01)
      $display("FAIL bp_release got rsp0_v=%b req1_ready=%b want 0,1", obs_rsp0_valid, obs_req1_ready);
    else n_pass++;
    @(posedge clk);
    #1 set_req(1'b1, 1'b0, a1, b1, 4'b0100);
    @(negedge clk); @(negedge clk); #1;
    n_checks++;
    if ({obs_rsp1_valid, obs_rsp1_out, obs_rsp1_cond} !== {1'b1, a1 ^ b1, 1'b0})
      $display("FAIL bp_port1 got v=%b out=%h want v=1 out=%h", obs_rsp1_valid, obs_rsp1_out, a1 ^ b1);
    else n_pass++;
    @(posedge clk);
  endtask

  task automatic test_arbitration(input bit fair);
    logic [31:0] opa[2], opb[2];
    logic [3:0]  opo[2];
    int          remain[2];
    int          grants[$];
    logic [32:0] inf_exp;
    bit          inf_port, p, last;
    int          done, cyc, r0, r1, w;
    sel_fp = ~fair;
    do_reset();
    remain[0] = 4; remain[1] = 4; done = 0; cyc = 0; inf_exp = 33'd0; inf_port = 1'b0;
    for (int k = 0; k < 2; k++) begin
      opa[k] = $urandom; opb[k] = $urandom; opo[k] = 4'($urandom_range(0, 15));
      set_req(k[0], 1'b1, opa[k], opb[k], opo[k]);
    end
    while (done < 8 && cyc < 200) begin
      #1; cyc++;
      if (obs_req0_ready && obs_req1_ready) begin
        n_checks++;
        $display("FAIL arb_both_ready fair=%0d got=11 want one-hot", fair);
      end
      if (obs_rsp0_valid || obs_rsp1_valid) begin
        n_checks++;
        if ({obs_rsp0_valid, obs_rsp1_valid} !== (inf_port ? 2'b01 : 2'b10))
          $display("FAIL arb_rsp_port fair=%0d got v=%b%b want owner=%0d", fair, obs_rsp0_valid, obs_rsp1_valid, inf_port);
        else n_pass++;
        n_checks++;
        if ((inf_port ? {obs_rsp1_out, obs_rsp1_cond} : {obs_rsp0_out, obs_rsp0_cond}) !== inf_exp)
          $display("FAIL arb_rsp_data fair=%0d port=%0d want=%h", fair, inf_port, inf_exp);
        else n_pass++;
        done++;
      end
      if (obs_req0_ready || obs_req1_ready) begin
        p = obs_req1_ready;
        grants.push_back(int'(p));
        inf_port = p;
        inf_exp  = expect_rsp(opa[p], opb[p], opo[p]);
        @(posedge clk);
        #1;
        remain[p]--;
        opa[p] = $urandom; opb[p] = $urandom; opo[p] = 4'($urandom_range(0, 15));
        set_req(p, remain[p] > 0, opa[p], opb[p], opo[p]);
      end
      @(negedge clk);
    end
    n_checks++;
    if (grants.size() !== 8 || done !== 8)
      $display("FAIL arb_count fair=%0d got grants=%0d rsps=%0d want 8,8", fair, grants.size(), done);
    else n_pass++;
    r0 = 4; r1 = 4; last = 1'b1;
    for (int i = 0; i < 8 && i < grants.size(); i++) begin
      if (r0 > 0 && r1 > 0) w = fair ? int'(!last) : 0;
      else w = (r0 > 0) ? 0 : 1;
      if (w == 0) r0--; else r1--;
      last = w[0];
      n_checks++;
      if (grants[i] !== w) $display("FAIL arb_order fair=%0d idx=%0d got=%0d want=%0d", fair, i, grants[i], w);
      else n_pass++;
    end
    sel_fp = 1'b0;
    do_reset();
  endtask

  task automatic test_mid_reset();
    int n;
    do_reset();
    set_req(1'b0, 1'b1, 32'd10, 32'd20, 4'd0);
    @(posedge clk);
    #1 set_req(1'b0, 1'b0, 32'd10, 32'd20, 4'd0);
    @(negedge clk);
    rst_n = 1'b0;
    set_req(1'b1, 1'b1, 32'd1, 32'd1, 4'd0);
    @(posedge clk);
    #1;
    n_checks++;
    if ({obs_alu_a, obs_alu_b, obs_rsp0_valid, obs_rsp1_valid, obs_req0_ready, obs_req1_ready} !== 68'd0)
      $display("FAIL rst_exec got a=%h b=%h v=%b%b r=%b%b want 0", obs_alu_a, obs_alu_b,
               obs_rsp0_valid, obs_rsp1_valid, obs_req0_ready, obs_req1_ready);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    set_req(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
    rsp0_ready = 1'b0;
    set_req(1'b0, 1'b1, 32'd10, 32'd20, 4'd0);
    @(posedge clk);
    #1 set_req(1'b0, 1'b0, 32'd10, 32'd20, 4'd0);
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!obs_rsp0_valid && n < 10);
    n_checks++;
    if ({obs_rsp0_valid, obs_rsp0_out} !== {1'b1, 32'd30}) $display("FAIL rst_resp_pre got v=%b out=%h want 1/1e", obs_rsp0_valid, obs_rsp0_out);
    else n_pass++;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({obs_alu_a, obs_alu_b, obs_alu_op, obs_rsp0_valid, obs_rsp0_out, obs_rsp0_cond} !== 102'd0)
      $display("FAIL rst_resp got a=%h v=%b out=%h want 0", obs_alu_a, obs_rsp0_valid, obs_rsp0_out);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    rsp0_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_checks++;
      if ({obs_rsp0_valid, obs_rsp1_valid} !== 2'b00) $display("FAIL rst_no_rsp cyc=%0d got=%b%b want=00", i, obs_rsp0_valid, obs_rsp1_valid);
      else n_pass++;
    end
    set_req(1'b0, 1'b1, 32'd100, 32'd1, 4'd1);
    set_req(1'b1, 1'b1, 32'd7, 32'd7, 4'd0);
    #1;
    n_checks++;
    if ({obs_req0_ready, obs_req1_ready} !== 2'b10) $display("FAIL rst_contend got=%b%b want=10", obs_req0_ready, obs_req1_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    set_req(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
    @(negedge clk); @(negedge clk); #1;
    n_checks++;
    if ({obs_rsp0_valid, obs_rsp0_out} !== {1'b1, 32'd99}) $display("FAIL rst_after_op got v=%b out=%h want 1/63", obs_rsp0_valid, obs_rsp0_out);
    else n_pass++;
    @(posedge clk);
  endtask

  task automatic test_random();
    logic [31:0] a, b; logic [3:0] op; logic [32:0] got, exp; int w, lat; bit to, port;
    for (int i = 0; i < 30; i++) begin
      a = $urandom; b = $urandom; op = 4'($urandom_range(0, 15)); port = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) b = b & 32'h0000_001f;
      exp = expect_rsp(a, b, op);
      run_op(port, a, b, op, got, w, lat, to);
      n_checks++;
      if ({to, lat, got} !== {1'b0, 32'd2, exp})
        $display("FAIL rand_op i=%0d port=%0d op=%h got=%h/%b lat=%0d to=%0d want=%h/%b lat=2",
                 i, port, op, got[32:1], got[0], lat, to, exp[32:1], exp[0]);
      else n_pass++;
    end
  endtask

  initial begin
    rst_n = 1'b0; force_cond = 1'b0; sel_fp = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    set_req(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
    test_reset();
    test_single_add();
    test_compare_cleaning();
    test_reserved_shifts();
    test_backpressure();
    test_arbitration(1'b1);
    test_arbitration(1'b0);
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
